// File: rtl/reg_file_mp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : reg_file_mp
// Desc    : Multi-read-port register file with a post-reset zero sweep, x0
//           hardwired to zero. Define REGFILE_BYPASS_EN for write-through reads.
// Rev     : 1.0
// ---------------------------------------------------------------------------
module reg_file_mp #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*XLEN-1:0]   rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [XLEN-1:0]          wr_data,
    output logic                     ready,
    output logic                     wr_ack
);

    localparam int                c_DEPTH     = 2 ** ADDR_W;
    localparam logic [0:0]        c_ST_CLEAR  = 1'b0;
    localparam logic [0:0]        c_ST_RUN    = 1'b1;
    localparam logic [ADDR_W-1:0] c_CNT_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_CNT_LAST  = ADDR_W'(c_DEPTH - 1);
`ifdef REGFILE_BYPASS_EN
    localparam bit                c_BYPASS    = 1'b1;
`else
    localparam bit                c_BYPASS    = 1'b0;
`endif

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              w_clear_we;
    logic              w_wr_accept;
    logic              r_wr_ack;
    logic [XLEN-1:0]   r_mem [c_DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_CLEAR;
            r_cnt    <= c_CNT_FIRST;
            r_wr_ack <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_wr_ack <= w_wr_accept;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_clear_we  = 1'b0;
        case (r_state)
            c_ST_CLEAR: begin
                w_clear_we = 1'b1;
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = c_ST_RUN;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_FIRST;
                end
            end
            c_ST_RUN: begin
                w_state_nxt = c_ST_RUN;
            end
            default: begin
                w_state_nxt = c_ST_CLEAR;
            end
        endcase
    end

    // Writes landing in a reset cycle are dropped, so rst gates acceptance.
    assign w_wr_accept = (r_state == c_ST_RUN) && wr_en && (wr_addr != '0) && !rst;

    // Entry 0 is never written; reads of address 0 are forced to zero below.
    always_ff @(posedge clk) begin
        if (w_clear_we) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_accept) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign ready  = (r_state == c_ST_RUN);
    assign wr_ack = r_wr_ack;

    generate
        for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
            logic [ADDR_W-1:0] w_addr;
            logic [XLEN-1:0]   w_data;

            assign w_addr = rd_addr[i*ADDR_W +: ADDR_W];

            always_comb begin
                w_data = r_mem[w_addr];
                if (!ready || (w_addr == '0)) begin
                    w_data = '0;
                end else if (c_BYPASS && w_wr_accept && (w_addr == wr_addr)) begin
                    w_data = wr_data;
                end
            end

            assign rd_data[i*XLEN +: XLEN] = w_data;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_reg_file_mp
// Desc    : Scoreboard bench for reg_file_mp (default and 4-port/64-bit builds).
// Rev     : 1.0
// ---------------------------------------------------------------------------
module tb_reg_file_mp;

`ifdef REGFILE_BYPASS_EN
    localparam logic [31:0] c_HZ_EXP = 32'd9;
`else
    localparam logic [31:0] c_HZ_EXP = 32'd7;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        ready;
    logic        wr_ack;

    logic         rst4;
    logic [11:0]  rd_addr4;
    logic [255:0] rd_data4;
    logic         wr_en4;
    logic [2:0]   wr_addr4;
    logic [63:0]  wr_data4;
    logic         ready4;
    logic         wr_ack4;

    reg_file_mp dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ready(ready), .wr_ack(wr_ack)
    );

    reg_file_mp #(.XLEN(64), .ADDR_W(3), .NUM_RD(4)) dut4 (
        .clk(clk), .rst(rst4), .rd_addr(rd_addr4), .rd_data(rd_data4),
        .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4),
        .ready(ready4), .wr_ack(wr_ack4)
    );

    int n_chk  = 0;
    int n_fail = 0;

    string       name_q[$];
    int          kind_q[$];
    logic [63:0] exp_q[$];

    logic [63:0] vals4 [8] = '{64'h0, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF,
                               64'h8000_0000_0000_0001, 64'h0000_0001_0000_0000,
                               64'hDEAD_BEEF_CAFE_F00D, 64'h7FFF_0000_FFFF_0000,
                               64'h0000_0000_0000_00A5};

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] observe(input int kind);
        case (kind)
            0:       return 64'(rd_data[31:0]);
            1:       return 64'(rd_data[63:32]);
            2:       return 64'(ready);
            3:       return 64'(wr_ack);
            4, 5, 6, 7: return rd_data4[(kind-4)*64 +: 64];
            8:       return 64'(ready4);
            default: return 64'(wr_ack4);
        endcase
    endfunction

    task automatic expect_at(input string nm, input int kind, input logic [63:0] exp);
        name_q.push_back(nm);
        kind_q.push_back(kind);
        exp_q.push_back(exp);
    endtask

    // Monitor: compares every queued expectation against the outputs mid-cycle.
    always @(negedge clk) begin
        while (kind_q.size() > 0) begin
            check(name_q.pop_front(), observe(kind_q[0]), exp_q.pop_front());
            void'(kind_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input string nm);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
        expect_at({nm, "_ack"}, 3, 64'd1);
    endtask

    task automatic rd2(input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] e0, input logic [31:0] e1, input string nm);
        rd_addr = {a1, a0};
        expect_at({nm, "_p0"}, 0, 64'(e0));
        expect_at({nm, "_p1"}, 1, 64'(e1));
        tick();
    endtask

    task automatic wait_ready(input int start, input int exp_cyc, input string nm);
        int cyc;
        cyc = start;
        while (!ready && cyc < 100) begin
            tick();
            cyc++;
        end
        check(nm, 64'(cyc), 64'(exp_cyc));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst = 1'b1; rd_addr = {5'd2, 5'd1}; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rst4 = 1'b1; rd_addr4 = '0; wr_en4 = 1'b0; wr_addr4 = '0; wr_data4 = '0;

        tick();
        expect_at("rst_ready", 2, 64'd0);
        expect_at("rst_ack", 3, 64'd0);
        expect_at("clear_p0", 0, 64'd0);
        expect_at("clear_p1", 1, 64'd0);
        rst = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h55;
        tick();
        wr_en = 1'b0;
        expect_at("clear_wr_ack", 3, 64'd0);
        wait_ready(1, 31, "ready_latency");

        for (int i = 0; i < 32; i++) begin
            rd2(5'(i), 5'(31 - i), 32'd0, 32'd0, "sweep_zero");
        end

        wr(5'd1, 32'd5, "w_x1");
        wr(5'd2, 32'd10, "w_x2");
        rd2(5'd1, 5'd2, 32'd5, 32'd10, "rd_x1x2");
        expect_at("single_ack", 3, 64'd0);
        rd2(5'd2, 5'd1, 32'd10, 32'd5, "rd_swap");
        rd2(5'd1, 5'd1, 32'd5, 32'd5, "same_reg");

        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEAD_BEEF;
        tick();
        wr_en = 1'b0;
        expect_at("x0_ack", 3, 64'd0);
        rd2(5'd0, 5'd0, 32'd0, 32'd0, "x0_rd");

        wr(5'd5, 32'hA5A5_F00F, "w_x5");
        rd2(5'd5, 5'd0, 32'hA5A5_F00F, 32'd0, "full_width");

        wr(5'd3, 32'd7, "w_x3");
        rd2(5'd3, 5'd0, 32'd7, 32'd0, "x3_old");
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'd9; rd_addr = {5'd1, 5'd3};
        expect_at("hazard_same_cycle", 0, 64'(c_HZ_EXP));
        tick();
        wr_en = 1'b0;
        expect_at("hazard_ack", 3, 64'd1);
        rd2(5'd3, 5'd1, 32'd9, 32'd5, "hazard_next");

        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_at("restart_ready", 2, 64'd0);
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h66;
        tick();
        rst = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
        tick();
        wr_en = 1'b0;
        expect_at("midsweep_wr_ack", 3, 64'd0);
        wait_ready(1, 31, "midsweep_latency");
        rd2(5'd4, 5'd1, 32'd0, 32'd0, "after_sweep_a");
        rd2(5'd6, 5'd3, 32'd0, 32'd0, "after_sweep_b");

        tick();
        rst4 = 1'b0;
        cyc = 0;
        while (!ready4 && cyc < 100) begin
            tick();
            cyc++;
        end
        check("p4_ready_latency", 64'(cyc), 64'd7);
        for (int i = 1; i < 8; i++) begin
            wr_en4 = 1'b1; wr_addr4 = 3'(i); wr_data4 = vals4[i];
            tick();
            expect_at("p4_ack", 9, 64'd1);
        end
        wr_en4 = 1'b0;
        rd_addr4 = {3'd4, 3'd3, 3'd2, 3'd1};
        for (int p = 0; p < 4; p++) expect_at("p4_rd_a", 4 + p, vals4[p + 1]);
        tick();
        rd_addr4 = {3'd7, 3'd6, 3'd5, 3'd0};
        expect_at("p4_rd_b0", 4, 64'd0);
        for (int p = 1; p < 4; p++) expect_at("p4_rd_b", 4 + p, vals4[p + 4]);
        tick();
        tick();
        check("scoreboard_drained", 64'(kind_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
